// File: rtl/if_fetch_buffer.sv
// if_fetch_buffer: instruction-fetch front end. It drives the instruction
// memory bus, queues fetched {instruction, pc} pairs in a small circular
// FIFO and hands them to decode through a valid/ready handshake. A redirect
// flushes the queue and restarts fetch at the new (word-aligned) PC.
module if_fetch_buffer #(
   parameter int unsigned     XLEN     = 32,
   parameter int unsigned     DEPTH    = 4,
   parameter logic [XLEN-1:0] RESET_PC = '0,
   parameter int unsigned     CW       = $clog2(DEPTH + 1)
) (
   input  logic            clk,
   input  logic            rst,
   output logic [XLEN-1:0] IAD,
   output logic            IREQ,
   input  logic            ACKI_n,
   input  logic [XLEN-1:0] IDT,
   input  logic            redirect,
   input  logic [XLEN-1:0] redirect_pc,
   input  logic            id_ready,
   output logic            inst_valid,
   output logic [XLEN-1:0] inst,
   output logic [XLEN-1:0] inst_pc,
   output logic [XLEN-1:0] inst_pc4,
   output logic [CW-1:0]   count
);

   localparam int unsigned     PW     = $clog2(DEPTH);
   localparam logic [CW-1:0]   FULL_C = CW'(DEPTH);
   localparam logic [PW-1:0]   LAST_C = PW'(DEPTH - 1);
   localparam logic [XLEN-1:0] STEP_C = XLEN'(4);

   logic [XLEN-1:0] inst_mem_q [DEPTH];
   logic [XLEN-1:0] pc_mem_q   [DEPTH];
   logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
   logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [CW-1:0]   count_q, count_d;
   logic            push;
   logic            pop;

   // Pointers wrap at DEPTH, which need not be a power of two.
   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == LAST_C) ? '0 : p + PW'(1);
   endfunction

   // Request whenever there is room; redirect kills the request in the same
   // cycle so a late acknowledge cannot slip a stale word into the queue.
   assign IREQ       = !rst && !redirect && (count_q != FULL_C);
   assign push       = IREQ && !ACKI_n;
   assign pop        = (count_q != '0) && id_ready && !redirect;

   assign IAD        = fetch_pc_q;
   assign inst_valid = (count_q != '0);
   assign inst       = inst_mem_q[rd_ptr_q];
   assign inst_pc    = pc_mem_q[rd_ptr_q];
   assign inst_pc4   = pc_mem_q[rd_ptr_q] + STEP_C;
   assign count      = count_q;

   // Next-state for fetch PC, pointers and occupancy; redirect wins over all.
   always_comb begin
      fetch_pc_d = fetch_pc_q;
      rd_ptr_d   = rd_ptr_q;
      wr_ptr_d   = wr_ptr_q;
      count_d    = count_q;
      if (redirect) begin
         fetch_pc_d = {redirect_pc[XLEN-1:2], 2'b00};
         rd_ptr_d   = '0;
         wr_ptr_d   = '0;
         count_d    = '0;
      end else begin
         if (push) begin
            wr_ptr_d   = ptr_inc(wr_ptr_q);
            fetch_pc_d = fetch_pc_q + STEP_C;
         end
         if (pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
         end
         count_d = count_q + CW'(push) - CW'(pop);
      end
   end

   // Control state registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fetch_pc_q <= RESET_PC;
         rd_ptr_q   <= '0;
         wr_ptr_q   <= '0;
         count_q    <= '0;
      end else begin
         fetch_pc_q <= fetch_pc_d;
         rd_ptr_q   <= rd_ptr_d;
         wr_ptr_q   <= wr_ptr_d;
         count_q    <= count_d;
      end
   end

   // FIFO storage; cleared on reset so the head reads as zero afterwards.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < int'(DEPTH); i++) begin
            inst_mem_q[i] <= '0;
            pc_mem_q[i]   <= '0;
         end
      end else if (push) begin
         inst_mem_q[wr_ptr_q] <= IDT;
         pc_mem_q[wr_ptr_q]   <= fetch_pc_q;
      end
   end

endmodule

// File: tb/tb_if_fetch_buffer.sv
// Testbench for if_fetch_buffer: directed scenarios followed by random
// traffic, checked against a queue-based reference model and scoreboard.
module tb_if_fetch_buffer;

   localparam int          DEPTH    = 4;
   localparam logic [31:0] RESET_PC = 32'h0;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] IAD;
   logic        IREQ;
   logic        ACKI_n;
   logic [31:0] IDT;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        id_ready;
   logic        inst_valid;
   logic [31:0] inst;
   logic [31:0] inst_pc;
   logic [31:0] inst_pc4;
   logic [2:0]  count;

   int n_chk  = 0;
   int n_pass = 0;
   bit hold_idt = 1'b0;

   // Reference model: fetch PC plus a queue of {instruction, pc} entries
   // that the DUT currently holds, oldest first.
   logic [31:0] fetch_pc_m;
   logic [63:0] sb_q[$];
   logic        ireq_m = 1'b0;

   if_fetch_buffer #(.XLEN(32), .DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
      .clk(clk), .rst(rst), .IAD(IAD), .IREQ(IREQ), .ACKI_n(ACKI_n), .IDT(IDT),
      .redirect(redirect), .redirect_pc(redirect_pc), .id_ready(id_ready),
      .inst_valid(inst_valid), .inst(inst), .inst_pc(inst_pc),
      .inst_pc4(inst_pc4), .count(count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
   endtask

   // Model update at each edge, from the inputs that were stable before it.
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         fetch_pc_m = RESET_PC;
         sb_q.delete();
      end else if (redirect) begin
         sb_q.delete();
         fetch_pc_m = {redirect_pc[31:2], 2'b00};
      end else if (ireq_m && !ACKI_n) begin
         sb_q.push_back({IDT, fetch_pc_m});
         fetch_pc_m = fetch_pc_m + 32'd4;
      end
   end

   // Monitor: compare bus/occupancy against the model, compare the head
   // against the scoreboard, and retire it when decode accepts it.
   always @(negedge clk) begin
      logic [63:0] head;
      if (rst) begin
         ireq_m = 1'b0;
         chk("mon_rst_ireq", {31'b0, IREQ}, 32'd0);
         chk("mon_rst_count", {29'b0, count}, 32'd0);
         chk("mon_rst_iad", IAD, RESET_PC);
      end else begin
         ireq_m = !redirect && (sb_q.size() < DEPTH);
         chk("mon_ireq", {31'b0, IREQ}, {31'b0, ireq_m});
         chk("mon_iad", IAD, fetch_pc_m);
         chk("mon_count", {29'b0, count}, sb_q.size());
         chk("mon_valid", {31'b0, inst_valid}, {31'b0, sb_q.size() != 0});
         if (inst_valid) begin
            if (sb_q.size() == 0) begin
               chk("mon_head_empty_sb", 32'd1, 32'd0);
            end else begin
               head = sb_q[0];
               chk("mon_inst", inst, head[63:32]);
               chk("mon_inst_pc", inst_pc, head[31:0]);
               chk("mon_inst_pc4", inst_pc4, head[31:0] + 32'd4);
               if (id_ready && !redirect) void'(sb_q.pop_front());
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
      if (!hold_idt) IDT = $urandom;
   endtask

   initial begin
      rst = 1'b1; ACKI_n = 1'b1; IDT = 32'h0; redirect = 1'b0;
      redirect_pc = 32'h0; id_ready = 1'b0;
      hold_idt = 1'b1;
      repeat (3) tick();
      chk("rst_iad", IAD, 32'h0);
      chk("rst_ireq", {31'b0, IREQ}, 32'd0);
      chk("rst_valid", {31'b0, inst_valid}, 32'd0);
      chk("rst_inst", inst, 32'h0);

      // Reset release with zero-wait memory: one instruction per cycle.
      rst = 1'b0; ACKI_n = 1'b0; IDT = 32'h0000_0013; id_ready = 1'b1;
      #1;
      chk("first_iad", IAD, 32'h0);
      chk("first_ireq", {31'b0, IREQ}, 32'd1);
      tick();
      chk("first_valid", {31'b0, inst_valid}, 32'd1);
      chk("first_inst_pc", inst_pc, 32'h0);
      chk("first_inst", inst, 32'h13);
      chk("iad_4", IAD, 32'h4);
      tick();
      chk("iad_8", IAD, 32'h8);
      chk("steady_count", {29'b0, count}, 32'd1);
      hold_idt = 1'b0;
      repeat (4) tick();

      // Stall fill from a clean start at PC 0.
      redirect = 1'b1; redirect_pc = 32'h0; id_ready = 1'b0;
      tick();
      redirect = 1'b0;
      chk("flush_count", {29'b0, count}, 32'd0);
      repeat (4) tick();
      chk("fill_count", {29'b0, count}, 32'd4);
      chk("fill_ireq", {31'b0, IREQ}, 32'd0);
      chk("fill_iad", IAD, 32'h10);
      tick();
      chk("full_hold_iad", IAD, 32'h10);
      id_ready = 1'b1;
      chk("full_head_pc", inst_pc, 32'h0);
      tick();
      chk("unfull_count", {29'b0, count}, 32'd3);
      chk("unfull_ireq", {31'b0, IREQ}, 32'd1);
      chk("pop_order_pc", inst_pc, 32'h4);
      repeat (3) tick();

      // Wait states at PC 0x8.
      redirect = 1'b1; redirect_pc = 32'h8; id_ready = 1'b0;
      tick();
      redirect = 1'b0; ACKI_n = 1'b1;
      repeat (3) begin
         tick();
         chk("wait_iad", IAD, 32'h8);
         chk("wait_count", {29'b0, count}, 32'd0);
      end
      ACKI_n = 1'b0;
      tick();
      ACKI_n = 1'b1;
      chk("wait_push_pc", inst_pc, 32'h8);
      tick();
      chk("wait_one_entry", {29'b0, count}, 32'd1);

      // Redirect while full with an unaligned target.
      ACKI_n = 1'b0;
      repeat (3) tick();
      chk("redir_full_count", {29'b0, count}, 32'd4);
      redirect = 1'b1; redirect_pc = 32'h0000_0103;
      #1;
      chk("redir_ireq_low", {31'b0, IREQ}, 32'd0);
      tick();
      redirect = 1'b0;
      chk("redir_count", {29'b0, count}, 32'd0);
      chk("redir_iad", IAD, 32'h100);
      tick();
      chk("redir_valid", {31'b0, inst_valid}, 32'd1);
      chk("redir_pc", inst_pc, 32'h100);
      chk("redir_pc4", inst_pc4, 32'h104);

      // Simultaneous push and pop at count 3.
      tick(); tick();
      chk("pp_count_before", {29'b0, count}, 32'd3);
      id_ready = 1'b1;
      tick();
      chk("pp_count_after", {29'b0, count}, 32'd3);
      chk("pp_head", inst_pc, 32'h104);

      // Asynchronous reset between edges with two entries queued.
      redirect = 1'b1; redirect_pc = 32'h200; id_ready = 1'b0;
      tick();
      redirect = 1'b0;
      tick(); tick();
      chk("areset_pre_count", {29'b0, count}, 32'd2);
      #2 rst = 1'b1;
      #1;
      chk("areset_count", {29'b0, count}, 32'd0);
      chk("areset_ireq", {31'b0, IREQ}, 32'd0);
      chk("areset_valid", {31'b0, inst_valid}, 32'd0);
      chk("areset_iad", IAD, RESET_PC);
      chk("areset_inst", inst, 32'h0);
      chk("areset_inst_pc", inst_pc, 32'h0);
      tick(); tick();
      rst = 1'b0;

      // Random traffic: wait states, stalls, redirects and occasional resets.
      for (int i = 0; i < 2000; i++) begin
         ACKI_n      = ($urandom_range(0, 2) == 0);
         id_ready    = ($urandom_range(0, 3) != 0);
         redirect    = ($urandom_range(0, 39) == 0);
         redirect_pc = $urandom;
         rst         = ($urandom_range(0, 499) == 0);
         tick();
      end
      rst = 1'b0; redirect = 1'b0;
      repeat (2) tick();

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
